// File: rtl/ysyx_23060203_wbu.sv
// ----------------------------------------------------------------------------
// ysyx_23060203_wbu : write-back / commit stage.
//
// Takes one completed instruction per cycle from execute and:
//   - drives the GPR file write port (combinational pass-through),
//   - owns the machine-mode CSR file (mstatus, mtvec, mepc, mcause, mcycle,
//     mvendorid, marchid),
//   - handles ecall / mret / fence.i / CSR-write side effects. Any of these
//     causes a registered one-cycle flush with a redirect PC. fence.i first
//     runs an I-cache invalidate handshake.
//
// Ports:
//   clock, reset          clock; asynchronous active-low reset
//   in_valid / in_ready   commit handshake (ready only in RUN)
//   in_pc, in_gpr_*       committing instruction PC and GPR result
//   in_csr_*              CSR write request
//   in_exc/in_ret/in_fencei  ecall / mret / fence.i markers
//   gpr_wen/waddr/wdata   register-file write port
//   csr_raddr/csr_rdata   decode-stage CSR read port (combinational)
//   flush, flush_pc       registered redirect pulse and target
//   ic_flush_req/ack      I-cache invalidate handshake
// ----------------------------------------------------------------------------
module ysyx_23060203_wbu (
  input  logic        clock,
  input  logic        reset,
  output logic        in_ready,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_gpr_waddr,
  input  logic [31:0] in_gpr_wdata,
  input  logic        in_csr_wen,
  input  logic [11:0] in_csr_waddr,
  input  logic [31:0] in_csr_wdata,
  input  logic        in_exc,
  input  logic        in_ret,
  input  logic        in_fencei,
  output logic        gpr_wen,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        ic_flush_req,
  input  logic        ic_flush_ack
);

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  localparam logic [31:0] MSTATUS_RST   = 32'h0000_1800;
  localparam logic [31:0] MVENDORID_VAL = 32'h7973_7978;
  localparam logic [31:0] MARCHID_VAL   = 32'h015F_DEEB;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FENCE = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [63:0] mcycle_q;

  logic fire_s;
  logic exc_s;
  logic csr_we_s;
  logic [31:0] pc_next_s;

  assign fire_s    = in_valid & in_ready;
  assign exc_s     = fire_s & in_exc;
  // A CSR write only takes effect when no higher-priority commit effect is present.
  assign csr_we_s  = fire_s & in_csr_wen & ~in_exc & ~in_ret & ~in_fencei;
  assign pc_next_s = in_pc + 32'd4;

  // Control outputs decode straight from registered state, so flush has no path from in_*.
  assign in_ready     = (state_q == ST_RUN);
  assign ic_flush_req = (state_q == ST_FENCE);
  assign flush        = (state_q == ST_FLUSH);
  assign flush_pc     = target_q;

  // GPR write port: ecall never retires a register result.
  assign gpr_wen   = fire_s & (|in_gpr_waddr) & ~in_exc;
  assign gpr_waddr = in_gpr_waddr;
  assign gpr_wdata = in_gpr_wdata;

  // Next-state and redirect target selection, priority exc > ret > fencei > csr_wen.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      ST_RUN: begin
        if (fire_s) begin
          if (in_exc) begin
            target_d = mtvec_q;
            state_d  = ST_FLUSH;
          end else if (in_ret) begin
            target_d = mepc_q;  // pre-update mepc
            state_d  = ST_FLUSH;
          end else if (in_fencei) begin
            target_d = pc_next_s;
            state_d  = ST_FENCE;
          end else if (in_csr_wen) begin
            target_d = pc_next_s;
            state_d  = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FENCE: begin
        if (ic_flush_ack) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_FENCE;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // FSM state and latched redirect target.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      target_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // Next values of the writable CSRs: ecall trap update or explicit CSR write.
  always_comb begin
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    if (exc_s) begin
      mepc_d   = in_pc;
      mcause_d = CAUSE_ECALL_M;
    end else if (csr_we_s) begin
      case (in_csr_waddr)
        CSR_MSTATUS: mstatus_d = in_csr_wdata;
        CSR_MTVEC:   mtvec_d   = in_csr_wdata;
        CSR_MEPC:    mepc_d    = in_csr_wdata;
        CSR_MCAUSE:  mcause_d  = in_csr_wdata;
        default:     mstatus_d = mstatus_q;  // read-only or unknown: ignored
      endcase
    end else begin
      mstatus_d = mstatus_q;
    end
  end

  // Writable CSR registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mstatus_q <= MSTATUS_RST;
      mtvec_q   <= 32'd0;
      mepc_q    <= 32'd0;
      mcause_q  <= 32'd0;
    end else begin
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
    end
  end

  // Free-running 64-bit cycle counter, wraps naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcycle_q <= 64'd0;
    end else begin
      mcycle_q <= mcycle_q + 64'd1;
    end
  end

  // CSR read mux; no bypass because every CSR write flushes younger instructions.
  always_comb begin
    csr_rdata = 32'd0;
    case (csr_raddr)
      CSR_MSTATUS:   csr_rdata = mstatus_q;
      CSR_MTVEC:     csr_rdata = mtvec_q;
      CSR_MEPC:      csr_rdata = mepc_q;
      CSR_MCAUSE:    csr_rdata = mcause_q;
      CSR_MCYCLE:    csr_rdata = mcycle_q[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle_q[63:32];
      CSR_MVENDORID: csr_rdata = MVENDORID_VAL;
      CSR_MARCHID:   csr_rdata = MARCHID_VAL;
      default:       csr_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060203_wbu.sv
// ----------------------------------------------------------------------------
// Testbench for ysyx_23060203_wbu. A driver issues directed and random
// commits; each commit pushes its expected GPR write and/or flush event into
// a scoreboard queue, and a monitor pops/compares whenever the DUT shows
// gpr_wen or flush. CSR contents are tracked by a simple reference model.
// ----------------------------------------------------------------------------
module tb_ysyx_23060203_wbu;

  logic        clock;
  logic        reset;
  logic        in_ready;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [4:0]  in_gpr_waddr;
  logic [31:0] in_gpr_wdata;
  logic        in_csr_wen;
  logic [11:0] in_csr_waddr;
  logic [31:0] in_csr_wdata;
  logic        in_exc;
  logic        in_ret;
  logic        in_fencei;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        flush;
  logic [31:0] flush_pc;
  logic        ic_flush_req;
  logic        ic_flush_ack;

  ysyx_23060203_wbu dut (
    .clock(clock), .reset(reset), .in_ready(in_ready), .in_valid(in_valid),
    .in_pc(in_pc), .in_gpr_waddr(in_gpr_waddr), .in_gpr_wdata(in_gpr_wdata),
    .in_csr_wen(in_csr_wen), .in_csr_waddr(in_csr_waddr), .in_csr_wdata(in_csr_wdata),
    .in_exc(in_exc), .in_ret(in_ret), .in_fencei(in_fencei),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .flush(flush), .flush_pc(flush_pc),
    .ic_flush_req(ic_flush_req), .ic_flush_ack(ic_flush_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam int K_NORM = 0, K_CSR = 1, K_EXC = 2, K_RET = 3, K_FENCE = 4;

  typedef struct {
    bit          is_flush;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  // reference CSR state
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
  logic [11:0] rd_list [7] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hF11, 12'hF12, 12'h7C0};
  logic [11:0] wr_list [8] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hF11, 12'hB00, 12'hB80, 12'h123};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mstatus = 32'h0000_1800;
    m_mtvec   = 32'd0;
    m_mepc    = 32'd0;
    m_mcause  = 32'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hF11: return 32'h7973_7978;
      12'hF12: return 32'h015F_DEEB;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_csr_write(input logic [11:0] a, input logic [31:0] d);
    case (a)
      12'h300: m_mstatus = d;
      12'h305: m_mtvec   = d;
      12'h341: m_mepc    = d;
      12'h342: m_mcause  = d;
      default: ;
    endcase
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_csr_wen = 1'b0; in_exc = 1'b0; in_ret = 1'b0;
    in_fencei = 1'b0; ic_flush_ack = 1'b0;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic read_chk(input logic [11:0] a, input string name);
    csr_raddr = a;
    #1;
    chk(name, csr_rdata, model_read(a));
  endtask

  // Issue one commit; called at posedge+1 while the DUT is in RUN. Returns at
  // posedge+1 of the cycle in which the DUT is back in RUN.
  task automatic issue(input int kind, input logic [31:0] pc, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [11:0] ca, input logic [31:0] cd,
                       input int dly);
    logic [31:0] tgt;
    read_chk(rd_list[$urandom_range(0, 6)], "csr_read");
    chk("in_ready_run", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_pc = pc; in_gpr_waddr = wa; in_gpr_wdata = wd;
    in_csr_waddr = ca; in_csr_wdata = cd;
    in_csr_wen = (kind == K_CSR) || (kind == K_EXC && $urandom_range(0, 1) == 1);
    in_exc = (kind == K_EXC); in_ret = (kind == K_RET); in_fencei = (kind == K_FENCE);
    ic_flush_ack = (kind == K_NORM) && ($urandom_range(0, 3) == 0);  // ignored in RUN
    if (kind != K_EXC && wa != 5'd0) sb.push_back('{1'b0, wa, wd});
    tgt = pc + 32'd4;
    case (kind)
      K_EXC:   begin tgt = m_mtvec; m_mepc = pc; m_mcause = 32'd11; end
      K_RET:   tgt = m_mepc;
      K_CSR:   model_csr_write(ca, cd);
      default: ;
    endcase
    if (kind != K_NORM) sb.push_back('{1'b1, 5'd0, tgt});
    step();
    idle_inputs();
    if (kind == K_NORM) begin
      chk("no_ic_req_run", {31'd0, ic_flush_req}, 32'd0);
      return;
    end
    if (kind == K_FENCE) begin
      for (int d = 1; d <= dly; d++) begin
        chk("fence_req", {31'd0, ic_flush_req}, 32'd1);
        chk("fence_ready", {31'd0, in_ready}, 32'd0);
        if (d == dly) ic_flush_ack = 1'b1;
        step();
        ic_flush_ack = 1'b0;
      end
    end
    chk("flush_ready", {31'd0, in_ready}, 32'd0);
    chk("flush_noreq", {31'd0, ic_flush_req}, 32'd0);
    step();
    chk("ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  // Monitor: compare every presented GPR write / flush against the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        if (gpr_wen) begin
          if (sb.size() == 0 || sb[0].is_flush) begin
            tests++; fails++;
            $display("FAIL gpr_unexpected: got waddr %0d wdata 0x%08h, expected none", gpr_waddr, gpr_wdata);
          end else begin
            chk("gpr_waddr", {27'd0, gpr_waddr}, {27'd0, sb[0].addr});
            chk("gpr_wdata", gpr_wdata, sb[0].data);
            void'(sb.pop_front());
          end
        end
        if (flush) begin
          if (sb.size() == 0 || !sb[0].is_flush) begin
            tests++; fails++;
            $display("FAIL flush_unexpected: got flush_pc 0x%08h, expected no flush", flush_pc);
          end else begin
            chk("flush_pc", flush_pc, sb[0].data);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] c0, c1;
    int kind, r;
    reset = 1'b0;
    idle_inputs();
    in_pc = 32'd0; in_gpr_waddr = 5'd0; in_gpr_wdata = 32'd0;
    in_csr_waddr = 12'd0; in_csr_wdata = 32'd0; csr_raddr = 12'h300;
    model_reset();
    #12;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_flush_pc", flush_pc, 32'd0);
    chk("rst_ic_req", {31'd0, ic_flush_req}, 32'd0);
    read_chk(12'h300, "rst_mstatus");
    read_chk(12'hF12, "rst_marchid");
    @(posedge clock); #1 reset = 1'b1;
    step();

    // directed sequence
    issue(K_NORM, 32'h8000_0000, 5'd5, 32'hDEAD_BEEF, 12'h000, 32'd0, 1);
    issue(K_NORM, 32'h8000_0004, 5'd0, 32'hDEAD_BEEF, 12'h000, 32'd0, 1);
    issue(K_CSR,  32'h8000_0000, 5'd0, 32'd0, 12'h305, 32'h8000_0100, 1);
    read_chk(12'h305, "mtvec_written");
    issue(K_EXC,  32'h8000_0010, 5'd7, 32'h1234_5678, 12'h305, 32'hFFFF_FFFF, 1);
    read_chk(12'h341, "mepc_ecall");
    read_chk(12'h342, "mcause_ecall");
    read_chk(12'h305, "mtvec_kept");
    issue(K_RET,  32'h8000_0100, 5'd0, 32'd0, 12'h000, 32'd0, 1);
    issue(K_FENCE, 32'h8000_0020, 5'd0, 32'd0, 12'h000, 32'd0, 5);

    // random commits
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      kind = (r < 55) ? K_NORM : (r < 72) ? K_CSR : (r < 81) ? K_EXC : (r < 90) ? K_RET : K_FENCE;
      issue(kind, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            $urandom, wr_list[$urandom_range(0, 7)], $urandom, $urandom_range(1, 6));
      repeat ($urandom_range(0, 2)) step();
    end

    // reset pulse while waiting for the I-cache ack
    in_valid = 1'b1; in_fencei = 1'b1; in_pc = 32'h8000_0040; in_gpr_waddr = 5'd0;
    step();
    idle_inputs();
    step();
    chk("fence_before_rst", {31'd0, ic_flush_req}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rst_async_req", {31'd0, ic_flush_req}, 32'd0);
    chk("rst_async_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    model_reset();
    read_chk(12'h300, "rst2_mstatus");
    read_chk(12'h305, "rst2_mtvec");
    @(posedge clock); #1 reset = 1'b1;
    step();

    // mcycle advances by exactly one per cycle
    csr_raddr = 12'hB00; #1 c0 = csr_rdata;
    repeat (10) @(posedge clock);
    #2 c1 = csr_rdata;
    chk("mcycle_delta", c1 - c0, 32'd10);
    csr_raddr = 12'hB80; #1;
    chk("mcycleh_small", csr_rdata, 32'd0);
    step();

    // read-only CSRs ignore writes
    issue(K_CSR, 32'h8000_0050, 5'd0, 32'd0, 12'hF11, 32'h1111_2222, 1);
    read_chk(12'hF11, "mvendorid_ro");
    issue(K_CSR, 32'h8000_0060, 5'd0, 32'd0, 12'hB00, 32'hFFFF_0000, 1);
    csr_raddr = 12'hB00; #1;
    chk("mcycle_ro", {31'd0, (csr_rdata < 32'd1000)}, 32'd1);

    repeat (3) step();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_23060203_wbu.md
# ysyx_23060203_wbu

Write-back and commit stage: the final pipeline stage, directly downstream of the execute stage. It accepts one completed instruction per cycle, performs the GPR write, owns the machine-mode CSR file, and handles ecall/mret/fence.i/CSR-write side effects. Any control-changing commit produces a registered one-cycle pipeline flush with a redirect PC, and fence.i additionally runs an I-cache invalidate handshake.

## Interface
- No parameters.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low.
- `in_ready`  out  1  can commit this cycle (1 only in RUN).
- `in_valid`  in  1  upstream instruction valid (already gated by `flush` upstream).
- `in_pc`  in  32  PC of the committing instruction.
- `in_gpr_waddr`  in  5  destination GPR (0 means no write).
- `in_gpr_wdata`  in  32  GPR write data.
- `in_csr_wen`  in  1  CSR write request.
- `in_csr_waddr`  in  12  CSR address.
- `in_csr_wdata`  in  32  CSR write data.
- `in_exc`  in  1  ecall.
- `in_ret`  in  1  mret.
- `in_fencei`  in  1  fence.i.
- `gpr_wen`  out  1  register-file write enable.
- `gpr_waddr`  out  5  register-file write address.
- `gpr_wdata`  out  32  register-file write data.
- `csr_raddr`  in  12  decode-stage CSR read address.
- `csr_rdata`  out  32  combinational CSR read data.
- `flush`  out  1  registered flush pulse to all upstream stages.
- `flush_pc`  out  32  redirect target, valid while `flush` = 1.
- `ic_flush_req`  out  1  I-cache invalidate request.
- `ic_flush_ack`  in  1  I-cache invalidate complete (one-cycle pulse).

## Operation
- Commit (`fire`) = `in_valid & in_ready`.
- GPR write: `gpr_wen = fire & |in_gpr_waddr & ~in_exc`.
  - `gpr_waddr` and `gpr_wdata` pass straight through from the inputs.
- CSRs:
  - mstatus 0x300, RW, reset 0x0000_1800.
  - mtvec 0x305, RW, reset 0.
  - mepc 0x341, RW, reset 0.
  - mcause 0x342, RW, reset 0.
  - mcycle 0xB00/0xB80 (low/high of a 64-bit counter): read-only, +1 every cycle out of reset, wraps at 2^64.
  - mvendorid 0xF11 = 0x7973_7978, marchid 0xF12 = 0x015F_DEEB: constants.
  - Unknown addresses read 0; writes to them and to read-only CSRs are ignored.
- Commit side effects, priority exc > ret > fencei > csr_wen:
  - exc: mepc←in_pc, mcause←11; CSR write suppressed; target = mtvec.
  - ret: target = mepc (the value before any update in the same cycle).
  - fencei: target = in_pc+4; enter FENCE.
  - csr_wen: write CSR; target = in_pc+4.
- FSM:
  - RUN: `in_ready` = 1. A fire with any of exc/ret/csr_wen latches the target and goes to FLUSH; a fire with fencei latches the target and goes to FENCE; otherwise stay.
  - FENCE: `ic_flush_req` = 1, `in_ready` = 0. On `ic_flush_ack` go to FLUSH.
  - FLUSH: `flush` = 1, `flush_pc` = latched target, `in_ready` = 0. Next state is RUN.
- `csr_rdata` has no same-cycle write bypass. Every CSR write flushes younger instructions, so none is needed.

## Timing
- Reset (async assert): state RUN, `flush` 0, `flush_pc` 0, `ic_flush_req` 0, `in_ready` 1, CSRs and mcycle at reset values. Reset asserted mid-FENCE drops `ic_flush_req` immediately.
- GPR and CSR writes take effect at the clock edge ending the fire cycle N.
- Flush from exc/ret/csr_wen: N+1 `flush` = 1, N+2 RUN and `in_ready` = 1.
- fencei: `ic_flush_req` is high from N+1 until the cycle ack is seen (cycle M); `flush` at M+1; RUN at M+2.
  - An ack arriving while in RUN or FLUSH is ignored.
  - `ic_flush_req` is held until ack, with no timeout.
- `flush` and `flush_pc` are register outputs only; there is no combinational path from `in_*` to `flush`. This is required because the upstream `out_valid` depends on `flush`.
- mcycle increments every cycle regardless of FSM state.

## Test plan
- Reset, then fire gpr_waddr=5, wdata=0xDEADBEEF -> `gpr_wen` = 1 that cycle, `flush` never rises. Same fire with waddr=0 -> `gpr_wen` = 0.
- csr_wen to 0x305 = 0x8000_0100 at pc=0x8000_0000 -> N+1 `flush` = 1, `flush_pc` = 0x8000_0004, `in_ready` = 0; N+2 `csr_raddr`=0x305 reads 0x8000_0100.
- ecall at pc=0x8000_0010 with mtvec=0x8000_0100 -> `flush_pc` = 0x8000_0100; mepc=0x8000_0010, mcause=11; no GPR write.
- Next, mret -> `flush_pc` = 0x8000_0010.
- fence.i at pc=0x8000_0020 with ack delayed 5 cycles -> `ic_flush_req` high for 5 cycles with `in_ready` = 0; `flush` on the cycle after ack, `flush_pc` = 0x8000_0024.
- Reset pulse mid-FENCE -> `ic_flush_req` = 0 asynchronously, FSM in RUN. mcycle read twice 10 cycles apart -> difference 10. Writes to 0xF11 and 0xB00 do not change their read values.
